// File: rtl/led_step_ctrl_pkg.sv
// Shared types and constants for the LED chaser control stage: run-state
// encodings, speed range and the per-button press bundle.
package led_step_ctrl_pkg;

  localparam int SPEED_W = 2;

  typedef logic [SPEED_W-1:0] speed_t;

  localparam speed_t SPEED_MAX = speed_t'(3);

  typedef enum logic {
    PAUSED = 1'b0,
    RUN    = 1'b1
  } run_state_e;

  // One-cycle debounced press pulses, one per button.
  typedef struct packed {
    logic faster;
    logic slower;
    logic pause;
  } btn_press_t;

  // Left-shift applied to the base divide ratio: slowest speed divides by 8x.
  function automatic speed_t div_shift(input speed_t speed);
    return SPEED_MAX - speed;
  endfunction

endpackage

// File: rtl/led_step_ctrl_if.sv
// Button inputs and chaser-facing outputs of the control stage.
// master = stimulus/board side, slave = led_step_ctrl.
interface led_step_ctrl_if;
  import led_step_ctrl_pkg::*;

  logic   btn_faster;
  logic   btn_slower;
  logic   btn_pause;
  logic   step;
  logic   running;
  speed_t speed;

  modport master (
    output btn_faster,
    output btn_slower,
    output btn_pause,
    input  step,
    input  running,
    input  speed
  );

  modport slave (
    input  btn_faster,
    input  btn_slower,
    input  btn_pause,
    output step,
    output running,
    output speed
  );

endinterface

// File: rtl/led_step_ctrl_btn_debounce.sv
// One raw push-button to a single-cycle press pulse: two-flop synchronizer,
// stability counter, and registered rising-edge detect on the debounced level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             synced;
  logic             deb_q, deb_d;
  logic             deb_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign synced = sync_q[1];

  // The level flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement;
  // any agreement in between restarts the count.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    deb_d = deb_q;
    cnt_d = '0;
    if (synced != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values; blocking here would collapse the synchronizer.
      sync_q    <= {sync_q[0], btn_i};
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
      press_q   <= deb_q & ~deb_dly_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_step_ctrl.sv
// Control stage for the LED chaser: debounced speed/pause commands, run/pause
// FSM and the programmable step divider that produces the chaser shift enable.
module led_step_ctrl
  import led_step_ctrl_pkg::*;
#(
  parameter int unsigned STEP_DIV_BASE   = 6_250_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic           clk,
  input  logic           reset,
  led_step_ctrl_if.slave bus
);

  localparam int unsigned DIV_CNT_W = $clog2(STEP_DIV_BASE * 8);
  localparam logic [DIV_CNT_W-1:0] DIV_BASE = DIV_CNT_W'(STEP_DIV_BASE);

  logic       press_faster;
  logic       press_slower;
  logic       press_pause;
  btn_press_t press;

  run_state_e state_q, state_d;
  speed_t     speed_q, speed_d;
  logic       speed_chg;

  logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_CNT_W-1:0] div_last;
  logic                 step_q, step_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_faster (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (bus.btn_faster),
    .press_o (press_faster)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_slower (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (bus.btn_slower),
    .press_o (press_slower)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (bus.btn_pause),
    .press_o (press_pause)
  );

  assign press = '{faster: press_faster, slower: press_slower, pause: press_pause};

  // Run/pause FSM: each pause press toggles.
  always_comb begin
    state_d = state_q;
    if (press.pause) begin
      state_d = (state_q == RUN) ? PAUSED : RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Speed select: opposing presses cancel; a press at a limit is not a change.
  always_comb begin
    speed_d   = speed_q;
    speed_chg = 1'b0;
    if (press.faster && !press.slower) begin
      if (speed_q != SPEED_MAX) begin
        speed_d   = speed_q + speed_t'(1);
        speed_chg = 1'b1;
      end
    end else if (press.slower && !press.faster) begin
      if (speed_q != '0) begin
        speed_d   = speed_q - speed_t'(1);
        speed_chg = 1'b1;
      end
    end
  end

  assign div_last = (DIV_BASE << div_shift(speed_q)) - DIV_CNT_W'(1);

  // Step divider: a speed change restarts the count and suppresses a coincident
  // terminal count; while paused the count is frozen.
  always_comb begin
    div_cnt_d = div_cnt_q;
    step_d    = 1'b0;
    if (speed_chg) begin
      div_cnt_d = '0;
    end else if (state_q == RUN) begin
      if (div_cnt_q == div_last) begin
        div_cnt_d = '0;
        step_d    = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + DIV_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed_q   <= '0;
      div_cnt_q <= '0;
      step_q    <= 1'b0;
    end else begin
      speed_q   <= speed_d;
      div_cnt_q <= div_cnt_d;
      step_q    <= step_d;
    end
  end

  assign bus.step    = step_q;
  assign bus.running = (state_q == RUN);
  assign bus.speed   = speed_q;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed bench for led_step_ctrl with STEP_DIV_BASE=4, DEBOUNCE_CYCLES=3:
// step periods 32/16/8/4 for speeds 0..3, press effect 6 edges after first sample.
module tb_led_step_ctrl;
  import led_step_ctrl_pkg::*;

  localparam int unsigned DEB  = 3;
  localparam int unsigned BASE = 4;

  logic        clk;
  logic        reset;
  int unsigned cyc = 0;
  int unsigned last_step = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  led_step_ctrl_if bus();

  led_step_ctrl #(
    .STEP_DIV_BASE   (BASE),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index: at a negedge, cyc equals the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_step(input int unsigned budget, output int unsigned at, output bit seen);
    seen = 1'b0;
    at   = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.step === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
  endtask

  // Called at a negedge. Raises the chosen buttons, returns at the negedge after
  // the edge where the press takes effect, with outputs sampled one cycle earlier.
  task automatic press_btns(input logic f, input logic s, input logic p,
                            output int unsigned chg, output speed_t spd_before,
                            output logic run_before);
    bus.btn_faster = f;
    bus.btn_slower = s;
    bus.btn_pause  = p;
    chg = cyc + 1 + DEB + 3;
    while (cyc < chg - 1) @(negedge clk);
    spd_before = bus.speed;
    run_before = bus.running;
    @(negedge clk);
    bus.btn_faster = 1'b0;
    bus.btn_slower = 1'b0;
    bus.btn_pause  = 1'b0;
  endtask

  task automatic test_reset();
    int unsigned r, at;
    bit seen;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.step !== 1'b0) begin n_errors++; $display("FAIL reset_step: got %0b expected 0", bus.step); end
    n_checks++;
    if (bus.running !== 1'b1) begin n_errors++; $display("FAIL reset_running: got %0b expected 1", bus.running); end
    n_checks++;
    if (bus.speed !== 2'd0) begin n_errors++; $display("FAIL reset_speed: got %0d expected 0", bus.speed); end
    reset = 1'b0;
    r = cyc;
    wait_step(40, at, seen);
    n_checks++;
    if (!seen || at !== r + 32) begin n_errors++; $display("FAIL first_step_edge: got %0d expected %0d (seen=%0b)", at - r, 32, seen); end
    @(negedge clk);
    n_checks++;
    if (bus.step !== 1'b0) begin n_errors++; $display("FAIL step_width: got %0b expected 0", bus.step); end
    wait_step(40, at, seen);
    n_checks++;
    if (!seen || at !== r + 64) begin n_errors++; $display("FAIL step_period_32: got %0d expected %0d (seen=%0b)", at - r, 64, seen); end
    last_step = at;
  endtask

  task automatic test_bounce();
    bit pat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int unsigned exp_at, at;
    bit seen;
    for (int i = 0; i < 8; i++) begin
      bus.btn_faster = pat[i];
      @(negedge clk);
    end
    bus.btn_faster = 1'b0;
    idle(8);
    n_checks++;
    if (bus.speed !== 2'd0) begin n_errors++; $display("FAIL bounce_speed: got %0d expected 0", bus.speed); end
    exp_at = last_step;
    while (exp_at <= cyc) exp_at += 32;
    wait_step(40, at, seen);
    n_checks++;
    if (!seen || at !== exp_at) begin n_errors++; $display("FAIL bounce_phase: got %0d expected %0d", at, exp_at); end
    last_step = at;
  endtask

  task automatic test_faster();
    int unsigned exp_div [3] = '{16, 8, 4};
    int unsigned c, at, exp_at;
    bit seen;
    speed_t sb;
    logic rb;
    for (int i = 0; i < 3; i++) begin
      press_btns(1'b1, 1'b0, 1'b0, c, sb, rb);
      n_checks++;
      if (sb !== speed_t'(i)) begin n_errors++; $display("FAIL faster_before_%0d: got %0d expected %0d", i, sb, i); end
      n_checks++;
      if (bus.speed !== speed_t'(i + 1)) begin n_errors++; $display("FAIL faster_speed_%0d: got %0d expected %0d", i, bus.speed, i + 1); end
      wait_step(exp_div[i] + 4, at, seen);
      n_checks++;
      if (!seen || at !== c + exp_div[i]) begin n_errors++; $display("FAIL faster_restart_%0d: got %0d expected %0d", i, at - c, exp_div[i]); end
      last_step = at;
      wait_step(exp_div[i] + 4, at, seen);
      n_checks++;
      if (!seen || at !== last_step + exp_div[i]) begin n_errors++; $display("FAIL faster_period_%0d: got %0d expected %0d", i, at - last_step, exp_div[i]); end
      last_step = at;
    end
    press_btns(1'b1, 1'b0, 1'b0, c, sb, rb);
    n_checks++;
    if (bus.speed !== 2'd3) begin n_errors++; $display("FAIL faster_saturate: got %0d expected 3", bus.speed); end
    exp_at = last_step;
    while (exp_at <= c) exp_at += 4;
    wait_step(8, at, seen);
    n_checks++;
    if (!seen || at !== exp_at) begin n_errors++; $display("FAIL saturate_keeps_phase: got %0d expected %0d", at, exp_at); end
    last_step = at;
  endtask

  task automatic test_pause();
    int unsigned c, c2, held, at, exp_at, bad;
    bit seen;
    speed_t sb;
    logic rb;
    press_btns(1'b0, 1'b0, 1'b1, c, sb, rb);
    n_checks++;
    if (rb !== 1'b1) begin n_errors++; $display("FAIL pause_before: got %0b expected 1", rb); end
    n_checks++;
    if (bus.running !== 1'b0) begin n_errors++; $display("FAIL paused_running: got %0b expected 0", bus.running); end
    held = (c - last_step) % 4;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.step !== 1'b0 || bus.running !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL paused_quiet: got %0d bad cycles expected 0", bad); end
    press_btns(1'b0, 1'b0, 1'b1, c2, sb, rb);
    n_checks++;
    if (rb !== 1'b0) begin n_errors++; $display("FAIL resume_before: got %0b expected 0", rb); end
    n_checks++;
    if (bus.running !== 1'b1) begin n_errors++; $display("FAIL resumed_running: got %0b expected 1", bus.running); end
    exp_at = c2 + (4 - held);
    wait_step(8, at, seen);
    n_checks++;
    if (!seen || at !== exp_at) begin n_errors++; $display("FAIL resume_first_step: got %0d expected %0d", at, exp_at); end
    last_step = at;
    wait_step(8, at, seen);
    n_checks++;
    if (!seen || at !== last_step + 4) begin n_errors++; $display("FAIL resume_period: got %0d expected 4", at - last_step); end
    last_step = at;
  endtask

  task automatic test_both_and_slower();
    int unsigned chain_spd [2] = '{1, 0};
    int unsigned chain_div [2] = '{16, 32};
    int unsigned c, at, exp_at;
    bit seen;
    speed_t sb;
    logic rb;
    press_btns(1'b0, 1'b1, 1'b0, c, sb, rb);
    n_checks++;
    if (bus.speed !== 2'd2) begin n_errors++; $display("FAIL slower_to_2: got %0d expected 2", bus.speed); end
    wait_step(12, at, seen);
    n_checks++;
    if (!seen || at !== c + 8) begin n_errors++; $display("FAIL slower_restart_8: got %0d expected 8", at - c); end
    last_step = at;
    press_btns(1'b1, 1'b1, 1'b0, c, sb, rb);
    n_checks++;
    if (bus.speed !== 2'd2) begin n_errors++; $display("FAIL both_speed: got %0d expected 2", bus.speed); end
    exp_at = last_step;
    while (exp_at <= c) exp_at += 8;
    wait_step(20, at, seen);
    n_checks++;
    if (!seen || at !== exp_at) begin n_errors++; $display("FAIL both_phase: got %0d expected %0d", at, exp_at); end
    last_step = at;
    idle(8);
    for (int i = 0; i < 2; i++) begin
      press_btns(1'b0, 1'b1, 1'b0, c, sb, rb);
      n_checks++;
      if (bus.speed !== speed_t'(chain_spd[i])) begin n_errors++; $display("FAIL slower_speed_%0d: got %0d expected %0d", i, bus.speed, chain_spd[i]); end
      wait_step(chain_div[i] + 4, at, seen);
      n_checks++;
      if (!seen || at !== c + chain_div[i]) begin n_errors++; $display("FAIL slower_restart_%0d: got %0d expected %0d", i, at - c, chain_div[i]); end
      last_step = at;
    end
    press_btns(1'b0, 1'b1, 1'b0, c, sb, rb);
    n_checks++;
    if (bus.speed !== 2'd0) begin n_errors++; $display("FAIL slower_saturate: got %0d expected 0", bus.speed); end
    exp_at = last_step;
    while (exp_at <= c) exp_at += 32;
    wait_step(40, at, seen);
    n_checks++;
    if (!seen || at !== exp_at) begin n_errors++; $display("FAIL slower_sat_phase: got %0d expected %0d", at, exp_at); end
    last_step = at;
  endtask

  task automatic test_reset_mid();
    int unsigned c, r, at;
    bit seen;
    speed_t sb;
    logic rb;
    for (int i = 0; i < 3; i++) begin
      idle(8);
      press_btns(1'b1, 1'b0, 1'b0, c, sb, rb);
    end
    n_checks++;
    if (bus.speed !== 2'd3) begin n_errors++; $display("FAIL mid_setup_speed: got %0d expected 3", bus.speed); end
    idle(8);
    press_btns(1'b0, 1'b0, 1'b1, c, sb, rb);
    n_checks++;
    if (bus.running !== 1'b0) begin n_errors++; $display("FAIL mid_setup_paused: got %0b expected 0", bus.running); end
    idle(3);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.step !== 1'b0) begin n_errors++; $display("FAIL async_reset_step: got %0b expected 0", bus.step); end
    n_checks++;
    if (bus.running !== 1'b1) begin n_errors++; $display("FAIL async_reset_running: got %0b expected 1", bus.running); end
    n_checks++;
    if (bus.speed !== 2'd0) begin n_errors++; $display("FAIL async_reset_speed: got %0d expected 0", bus.speed); end
    @(negedge clk);
    reset = 1'b0;
    r = cyc;
    wait_step(40, at, seen);
    n_checks++;
    if (!seen || at !== r + 32) begin n_errors++; $display("FAIL post_reset_first_step: got %0d expected 32", at - r); end
  endtask

  initial begin
    reset          = 1'b1;
    bus.btn_faster = 1'b0;
    bus.btn_slower = 1'b0;
    bus.btn_pause  = 1'b0;
    test_reset();
    test_bounce();
    test_faster();
    test_pause();
    test_both_and_slower();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
